// File: rtl/modsub_issue.sv
// modsub_issue: valid/ready issue stage wrapped around the fixed-latency modsub core.
// Accepted operand pairs go straight to the core. A LAT-deep valid shift register marks
// when core_C carries a real result, which is captured in a credit-protected FIFO.
// The core cannot stall, so admission is limited by FIFO space, counting in-flight ops.
// Also holds the qH modulus configuration register feeding the core.
// Optional feature: define MODSUB_ISSUE_RANGE_CHK_EN to add the sticky err_range output.
module modsub_issue #(
    parameter int unsigned LOGA       = 64,
    parameter int unsigned LOGB       = 64,
    parameter int unsigned LOGQ       = 64,
    parameter int unsigned LOGQH      = 47,
    parameter int unsigned LAT        = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [LOGQH-1:0] cfg_qH,
    output logic             cfg_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGA-1:0]  in_A,
    input  logic [LOGB-1:0]  in_B,
    output logic [LOGA-1:0]  core_A,
    output logic [LOGB-1:0]  core_B,
    output logic [LOGQH-1:0] core_qH,
    input  logic [LOGQ-1:0]  core_C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  out_C
`ifdef MODSUB_ISSUE_RANGE_CHK_EN
    ,
    output logic             err_range
`endif
);

    // Shift register is kept at least one bit wide; it stays all-zero when LAT == 0.
    localparam int unsigned PW   = (LAT > 0) ? LAT : 1;
    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);
    // Wide enough to hold count + inflight (at most FIFO_DEPTH + 8).
    localparam int unsigned SUMW = $clog2(FIFO_DEPTH + 9) + 1;

    logic [PW-1:0]    vld_q, vld_d;
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [LOGQH-1:0] qh_q, qh_d;
    logic [LOGQ-1:0]  mem_q [FIFO_DEPTH];

    logic             fire;
    logic             push;
    logic             pop;
    logic [SUMW-1:0]  inflight;

    // Core is fed combinationally from the input stream and the qH register.
    always_comb begin
        core_A  = in_A;
        core_B  = in_B;
        core_qH = qh_q;
    end

    // Number of ops currently inside the core.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < int'(PW); k++) begin
            inflight = inflight + SUMW'(vld_q[k]);
        end
    end

    // Handshakes; in_ready depends on registered state only (no out_ready path).
    always_comb begin
        in_ready  = (SUMW'(cnt_q) + inflight) < SUMW'(FIFO_DEPTH);
        fire      = in_valid & in_ready;
        push      = (LAT == 0) ? fire : vld_q[PW-1];
        out_valid = (cnt_q != '0);
        pop       = out_valid & out_ready;
        out_C     = mem_q[rd_ptr_q];
        cfg_busy  = (inflight != '0) | (cnt_q != '0) | in_valid;
    end

    // Valid pipeline next state: shift in fire, mirrors the core's latency.
    always_comb begin
        vld_d = '0;
        if (LAT != 0) begin
            vld_d[0] = fire;
            for (int k = 1; k < int'(PW); k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    // FIFO pointer and occupancy next state; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTRW'(push);
        rd_ptr_d = rd_ptr_q + PTRW'(pop);
        cnt_d    = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNTW'(1);
            2'b01:   cnt_d = cnt_q - CNTW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // qH only changes when nothing is in the core or buffered, so every op sees one value.
    always_comb begin
        qh_d = qh_q;
        if (cfg_we && !cfg_busy) begin
            qh_d = cfg_qH;
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            qh_q     <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            qh_q     <= qh_d;
        end
    end

    // Result storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= core_C;
        end
    end

`ifdef MODSUB_ISSUE_RANGE_CHK_EN
    localparam int unsigned RW0 = (LOGA > LOGB) ? LOGA : LOGB;
    // One extra bit over LOGQ so q never overflows even when LOGQ == LOGQH.
    localparam int unsigned RW  = (RW0 > LOGQ + 1) ? RW0 : LOGQ + 1;

    logic [RW-1:0] q_full;
    logic          range_bad;
    logic          err_q, err_d;

    // q = qH * 2^(LOGQ-LOGQH) + 1 and the operand range test.
    always_comb begin
        q_full    = (RW'(qh_q) << (LOGQ - LOGQH)) + RW'(1);
        range_bad = (RW'(in_A) >= q_full) | (RW'(in_B) >= q_full);
        err_d     = err_q | (fire & range_bad);
        err_range = err_q;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_modsub_issue.sv
// tb_modsub_issue: randomized bench for modsub_issue with a behavioural core and a
// queue-based reference model of results, timing and configuration.
module tb_modsub_issue;

    localparam int unsigned LOGA       = 8;
    localparam int unsigned LOGB       = 8;
    localparam int unsigned LOGQ       = 8;
    localparam int unsigned LOGQH      = 5;
    localparam int unsigned LAT        = 3;
    localparam int unsigned FIFO_DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             cfg_we;
    logic [LOGQH-1:0] cfg_qH;
    logic             cfg_busy;
    logic             in_valid;
    logic             in_ready;
    logic [LOGA-1:0]  in_A;
    logic [LOGB-1:0]  in_B;
    logic [LOGA-1:0]  core_A;
    logic [LOGB-1:0]  core_B;
    logic [LOGQH-1:0] core_qH;
    logic [LOGQ-1:0]  core_C;
    logic             out_valid;
    logic             out_ready;
    logic [LOGQ-1:0]  out_C;
`ifdef MODSUB_ISSUE_RANGE_CHK_EN
    logic             err_range;
`endif

    modsub_issue #(
        .LOGA      (LOGA),
        .LOGB      (LOGB),
        .LOGQ      (LOGQ),
        .LOGQH     (LOGQH),
        .LAT       (LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_qH   (cfg_qH),
        .cfg_busy (cfg_busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_A     (in_A),
        .in_B     (in_B),
        .core_A   (core_A),
        .core_B   (core_B),
        .core_qH  (core_qH),
        .core_C   (core_C),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_C    (out_C)
`ifdef MODSUB_ISSUE_RANGE_CHK_EN
        ,
        .err_range(err_range)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // (a - b) mod q for operands below q; out-of-range operands still follow a-b(+q).
    function automatic int ref_sub(input int a, input int b, input int q);
        return (a >= b) ? (a - b) : (a - b + q);
    endfunction

    // Behavioural core: result appears LAT cycles after the operands are presented.
    logic [LOGQ-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= LOGQ'(ref_sub(int'(core_A), int'(core_B), int'(core_qH) * 8 + 1));
        for (int k = 1; k < int'(LAT); k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_C = core_pipe[LAT-1];

    typedef struct {
        int acc_cyc;
        int val;
    } ent_t;

    ent_t exp_q[$];
    int   pop_log[$];
    int   qh_m;
    bit   err_m;
    bit   armed;
    int   cyc;
    int   dut_out;
    int   dut_acc;
    int   n_pass;
    int   n_total;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock cycle: sample mid-cycle, compare, advance the model, move past the edge.
    task automatic step();
        bit exp_ready, exp_valid, exp_busy, fire, pop;
        int q;
        @(negedge clk);
        exp_ready = (exp_q.size() < int'(FIFO_DEPTH));
        exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].acc_cyc + int'(LAT) + 1);
        exp_busy  = (exp_q.size() != 0) || in_valid;
        if (armed) begin
            check("in_ready", 64'(in_ready), 64'(exp_ready));
            check("out_valid", 64'(out_valid), 64'(exp_valid));
            check("cfg_busy", 64'(cfg_busy), 64'(exp_busy));
            if (exp_valid) check("out_C", 64'(out_C), 64'(exp_q[0].val));
`ifdef MODSUB_ISSUE_RANGE_CHK_EN
            check("err_range", 64'(err_range), 64'(err_m));
`endif
            if (rst_n) begin
                if (in_valid && in_ready) begin
                    dut_out++;
                    dut_acc++;
                end
                if (out_valid && out_ready) dut_out--;
                if (in_valid && in_ready) check("no_overflow", 64'(dut_out <= int'(FIFO_DEPTH)), 64'(1));
            end
        end
        fire = in_valid && exp_ready;
        pop  = exp_valid && out_ready;
        if (!rst_n) begin
            exp_q.delete();
            qh_m    = 0;
            err_m   = 1'b0;
            dut_out = 0;
            armed   = 1'b1;
        end else begin
            if (pop) begin
                pop_log.push_back(exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (fire) begin
                q = qh_m * 8 + 1;
                exp_q.push_back('{acc_cyc: cyc, val: ref_sub(int'(in_A), int'(in_B), q)});
                if (int'(in_A) >= q || int'(in_B) >= q) err_m = 1'b1;
            end
            if (cfg_we && !exp_busy) qh_m = int'(cfg_qH);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int a, input int b);
        in_valid = 1'b1;
        in_A     = LOGA'(a);
        in_B     = LOGB'(b);
        step();
        in_valid = 1'b0;
    endtask

    task automatic load_qh(input int v);
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_qH   = LOGQH'(v);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) step();
    endtask

    initial begin
        int base;
        int q;
        n_pass = 0; n_total = 0; cyc = 0; armed = 1'b0; qh_m = 0; err_m = 1'b0;
        dut_out = 0; dut_acc = 0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_qH = '0; in_valid = 1'b0;
        in_A = '0; in_B = '0; out_ready = 1'b0;
        #1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic back-to-back issue with q = 121.
        load_qh(15);
        step();
        out_ready = 1'b1;
        pop_log.delete();
        in_valid = 1'b1;
        in_A = 8'd10; in_B = 8'd20; step();
        in_A = 8'd20; in_B = 8'd10; step();
        in_A = 8'd0;  in_B = 8'd0;  step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("basic_count", 64'(pop_log.size()), 64'(3));
        if (pop_log.size() >= 3) begin
            check("basic_r0", 64'(pop_log[0]), 64'(111));
            check("basic_r1", 64'(pop_log[1]), 64'(10));
            check("basic_r2", 64'(pop_log[2]), 64'(0));
        end

        // Backpressure: exactly FIFO_DEPTH pairs admitted, then in-order drain.
        out_ready = 1'b0;
        base = dut_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_A = LOGA'($urandom_range(120, 0));
            in_B = LOGB'($urandom_range(120, 0));
            step();
        end
        check("bp_accepted", 64'(dut_acc - base), 64'(FIFO_DEPTH));
        drain(12);

        // Continuous streaming with both sides ready: pointers wrap several times.
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_A = LOGA'($urandom_range(120, 0));
            in_B = LOGB'($urandom_range(120, 0));
            step();
        end
        drain(10);

        // cfg write while busy is ignored; later write while idle takes effect.
        pop_log.delete();
        issue(3, 10);
        issue(50, 60);
        load_qh(7);
        drain(8);
        issue(4, 9);
        drain(8);
        load_qh(7);
        issue(5, 9);
        drain(8);
        check("cfg_count", 64'(pop_log.size()), 64'(4));
        if (pop_log.size() >= 4) begin
            check("cfg_busy_r0", 64'(pop_log[0]), 64'(114));
            check("cfg_busy_r1", 64'(pop_log[1]), 64'(111));
            check("cfg_ignored", 64'(pop_log[2]), 64'(116));
            check("cfg_loaded", 64'(pop_log[3]), 64'(53));
        end

        // Randomized traffic with occasional configuration attempts.
        load_qh(15);
        for (int i = 0; i < 400; i++) begin
            q = qh_m * 8 + 1;
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            in_A      = LOGA'($urandom_range(q - 1, 0));
            in_B      = LOGB'($urandom_range(q - 1, 0));
            cfg_we    = ($urandom_range(15, 0) == 0);
            cfg_qH    = LOGQH'($urandom_range(31, 8));
            if (cfg_we && $urandom_range(1, 0) == 1) in_valid = 1'b0;
            step();
        end
        cfg_we = 1'b0;
        drain(12);

        // Reset mid-operation: results in flight and buffered must vanish.
        load_qh(15);
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_A = LOGA'($urandom_range(120, 0));
            in_B = LOGB'($urandom_range(120, 0));
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_cfg_busy", 64'(cfg_busy), 64'(0));
        drain(10);

`ifdef MODSUB_ISSUE_RANGE_CHK_EN
        // Range check: boundary operand q-1 is legal, q is flagged; result still produced.
        load_qh(15);
        pop_log.delete();
        issue(120, 5);
        drain(6);
        check("range_ok", 64'(err_range), 64'(0));
        issue(121, 5);
        drain(6);
        check("range_flag", 64'(err_range), 64'(1));
        if (pop_log.size() >= 2) check("range_result", 64'(pop_log[1]), 64'(116));
        else check("range_count", 64'(pop_log.size()), 64'(2));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
